// File: rtl/serializer.sv
// Parallel-to-serial converter: latches one word plus a bit count, then shifts
// the requested number of bits out MSB first, one bit per clock.
module serializer #(
  parameter int unsigned DATA_BUS_WIDTH = 16,
  parameter int unsigned MOD_WIDTH      = $clog2(DATA_BUS_WIDTH)
) (
  input  logic                      clk_i,
  input  logic                      srst_i,
  input  logic [DATA_BUS_WIDTH-1:0] data_i,
  input  logic [MOD_WIDTH-1:0]      data_mod_i,
  input  logic                      data_val_i,
  output logic                      ser_data_o,
  output logic                      ser_data_val_o,
  output logic                      busy_o
);

  // One extra bit so the counter can hold a full-width count without wrapping.
  localparam int unsigned CntW = MOD_WIDTH + 1;
  localparam logic [CntW-1:0] FullCnt = CntW'(DATA_BUS_WIDTH);

  typedef enum logic {
    StIdle,
    StSend
  } state_e;

  state_e                    state_q, state_d;
  logic [DATA_BUS_WIDTH-1:0] shift_q, shift_d;
  logic [CntW-1:0]           cnt_q, cnt_d;
  logic [CntW-1:0]           mod_ext;
  logic [CntW-1:0]           load_cnt;

  // Bit count for a new word: 0 means full width, oversize values are clamped.
  always_comb begin
    mod_ext  = {1'b0, data_mod_i};
    load_cnt = mod_ext;
    if (mod_ext == '0 || mod_ext > FullCnt) begin
      load_cnt = FullCnt;
    end
  end

  // Next-state logic: accept in idle, shift and count down while sending.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (data_val_i) begin
          shift_d = data_i;
          cnt_d   = load_cnt;
          state_d = StSend;
        end
      end
      StSend: begin
        shift_d = {shift_q[DATA_BUS_WIDTH-2:0], 1'b0};
        cnt_d   = cnt_q - 1'b1;
        // Last bit is on the wire this cycle; a request now is ignored.
        if (cnt_q == CntW'(1)) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers; reset aborts any word in flight immediately.
  always_ff @(posedge clk_i or posedge srst_i) begin
    if (srst_i) begin
      state_q <= StIdle;
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs decode registered state only; data is forced low when not valid.
  always_comb begin
    ser_data_val_o = (state_q == StSend);
    busy_o         = (state_q == StSend);
    ser_data_o     = (state_q == StSend) & shift_q[DATA_BUS_WIDTH-1];
  end

endmodule

// File: tb/tb_serializer.sv
// Self-checking bench for serializer: stimulus predicts the serial stream from
// the word/count rules and queues it; a negedge monitor checks the DUT output.
module tb_serializer;

  logic        clk_i = 1'b0;
  logic        srst_i = 1'b1;
  logic [15:0] data_i = '0;
  logic [3:0]  data_mod_i = '0;
  logic        data_val_i = 1'b0;
  logic        ser_data_o;
  logic        ser_data_val_o;
  logic        busy_o;

  serializer #(
    .DATA_BUS_WIDTH(16)
  ) dut (
    .clk_i         (clk_i),
    .srst_i        (srst_i),
    .data_i        (data_i),
    .data_mod_i    (data_mod_i),
    .data_val_i    (data_val_i),
    .ser_data_o    (ser_data_o),
    .ser_data_val_o(ser_data_val_o),
    .busy_o        (busy_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic b;
    int   e;
  } exp_t;

  exp_t q[$];
  int   edge_cnt = 0;
  int   free_at  = 0;
  int   tests    = 0;
  int   fails    = 0;

  always @(posedge clk_i) edge_cnt <= edge_cnt + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s at edge %0d: got %0h expected %0h", name, edge_cnt, got, exp);
    end
  endtask

  // Drive one cycle of inputs after a rising edge; the model decides whether
  // the following edge accepts the word and predicts every bit and its cycle.
  task automatic drive(input logic v, input logic [15:0] d, input logic [3:0] m);
    int e;
    int n;
    @(posedge clk_i);
    #2;
    data_val_i = v;
    data_i     = d;
    data_mod_i = m;
    e = edge_cnt + 1;
    if (v && !srst_i && e >= free_at) begin
      n = (m == 4'd0) ? 16 : int'(m);
      for (int k = 0; k < n; k++) q.push_back('{d[15-k], e + k});
      free_at = e + n + 1;
    end
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) drive(1'b0, 16'($urandom), 4'($urandom));
  endtask

  // Monitor: every valid bit must match the oldest prediction, in its cycle.
  always @(negedge clk_i) begin
    exp_t x;
    if (!srst_i) begin
      check("busy_eq_val", {31'd0, busy_o}, {31'd0, ser_data_val_o});
      if (ser_data_val_o) begin
        if (q.size() == 0) begin
          check("unexpected_valid", {31'd0, ser_data_val_o}, 32'd0);
        end else begin
          x = q.pop_front();
          check("ser_bit", {31'd0, ser_data_o}, {31'd0, x.b});
          check("bit_cycle", edge_cnt, x.e);
        end
      end else begin
        check("idle_data_zero", {31'd0, ser_data_o}, 32'd0);
        if (q.size() > 0 && q[0].e <= edge_cnt) begin
          check("missing_bit", {31'd0, ser_data_val_o}, 32'd1);
          void'(q.pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    #1;
    check("rst_ser_data", {31'd0, ser_data_o}, 32'd0);
    check("rst_val", {31'd0, ser_data_val_o}, 32'd0);
    check("rst_busy", {31'd0, busy_o}, 32'd0);
    @(posedge clk_i);
    @(posedge clk_i);
    #2;
    srst_i = 1'b0;
    idle(2);

    // Full word A5C3.
    drive(1'b1, 16'hA5C3, 4'd0);
    idle(18);

    // Short word: only the top three bits leave.
    drive(1'b1, 16'hF000, 4'd3);
    idle(5);

    // Requests at bit 5 and the last bit are ignored; held request re-accepts.
    drive(1'b1, 16'h8001, 4'd0);
    for (int i = 1; i <= 20; i++) begin
      if (i == 5 || i >= 15) drive(1'b1, 16'hFFFF, 4'd0);
      else                   drive(1'b0, 16'hFFFF, 4'd0);
    end
    idle(18);

    // Inputs churn during the transfer without effect.
    drive(1'b1, 16'h1234, 4'd0);
    for (int i = 0; i < 16; i++) drive(1'b0, 16'($urandom), 4'($urandom));
    idle(3);

    // Asynchronous reset mid-transfer at bit 7.
    drive(1'b1, 16'hBEEF, 4'd0);
    idle(7);
    #1;
    srst_i = 1'b1;
    #1;
    check("abort_ser_data", {31'd0, ser_data_o}, 32'd0);
    check("abort_val", {31'd0, ser_data_val_o}, 32'd0);
    check("abort_busy", {31'd0, busy_o}, 32'd0);
    q.delete();
    free_at = 0;
    idle(2);
    @(posedge clk_i);
    #2;
    srst_i = 1'b0;
    idle(4);
    drive(1'b1, 16'h0F0F, 4'd0);
    idle(18);

    // Single-bit word.
    drive(1'b1, 16'h8000, 4'd1);
    idle(3);

    // Randomized traffic, including requests while busy.
    for (int i = 0; i < 600; i++) begin
      drive(($urandom_range(0, 3) == 0), 16'($urandom), 4'($urandom));
    end
    idle(20);

    check("queue_drained", q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/serializer.md
Name: serializer

Overview:
- Parallel-to-serial converter. It is the transmit-side counterpart of the team's deserializer.
- Accepts one parallel word of up to DATA_BUS_WIDTH bits with a valid-bit count, then shifts it out one bit per clock, MSB first.
- Sits between a word-oriented producer and a single-bit serial link. The serial link drives a deserializer at the far end.

Parameters:
- DATA_BUS_WIDTH, 16: width of the parallel input word. Must be ≥ 2.
- MOD_WIDTH, $clog2(DATA_BUS_WIDTH): width of the bit-count input.

Ports:
- clk_i, input, 1: single clock. All logic is on the rising edge.
- srst_i, input, 1: reset, asynchronous, active-high.
- data_i, input, DATA_BUS_WIDTH: parallel word to transmit. Bit DATA_BUS_WIDTH-1 is sent first.
- data_mod_i, input, MOD_WIDTH: number of bits to send, taken from the MSB end. 0 means the full DATA_BUS_WIDTH.
- data_val_i, input, 1: word request. Sampled only while busy_o = 0.
- ser_data_o, output, 1: serial data bit.
- ser_data_val_o, output, 1: ser_data_o is valid this cycle.
- busy_o, output, 1: transfer in progress. Requests are ignored while it is high.

Behaviour:
- Reset (async assert, release synchronous to clk_i):
  - ser_data_o = 0, ser_data_val_o = 0, busy_o = 0.
  - Internal shift register = 0, bit counter = 0, FSM = IDLE.
- Reset mid-transfer aborts immediately. The aborted word is discarded and never resumed. No partial-state outputs persist past assertion.
- FSM has two states, IDLE and SEND.
- IDLE:
  - ser_data_val_o = 0, ser_data_o = 0, busy_o = 0.
  - If data_val_i = 1 at a rising edge:
    - latch data_i into the shift register;
    - load the counter with N = (data_mod_i == 0) ? DATA_BUS_WIDTH : data_mod_i;
    - go to SEND.
  - Otherwise stay in IDLE.
- SEND:
  - busy_o = 1, ser_data_val_o = 1, ser_data_o = shift-register MSB.
  - Each edge shifts the register left by one, filling with 0, and decrements the counter.
  - When the counter reaches 1 at an edge (the last bit is being presented), the next state is IDLE.
- Latency:
  - The first bit appears in the cycle after the accepting edge.
  - Exactly N consecutive cycles have ser_data_val_o = 1, carrying data_i[W-1] down to data_i[W-N].
  - The final bit is followed by at least one cycle with ser_data_val_o = 0.
- Outputs are registered. busy_o is asserted in the same cycles as ser_data_val_o.
- A request raised in the same cycle as the last bit is ignored, because busy_o = 1. The earliest re-accept is the first IDLE cycle after SEND, so the minimum gap between words is one idle cycle.
- data_i and data_mod_i are don't-care outside the accepting edge. Changing them mid-transfer has no effect.
- Counter width is MOD_WIDTH+1 so it can hold DATA_BUS_WIDTH without wrap. For non-power-of-two DATA_BUS_WIDTH, data_mod_i values greater than DATA_BUS_WIDTH are clamped to DATA_BUS_WIDTH.
- The far-end deserializer expects full words. A short word (N < DATA_BUS_WIDTH) is permitted on the link but is the producer's responsibility.
- No X propagation: ser_data_o is forced to 0 whenever ser_data_val_o = 0.

Test Plan:
- Reset, then data_i = 16'hA5C3, data_mod_i = 0, data_val_i pulsed one cycle -> starting the next cycle, 16 valid cycles with bits 1,0,1,0,0,1,0,1,1,1,0,0,0,0,1,1. busy_o = 1 for exactly those 16 cycles, then ser_data_val_o = 0.
- data_i = 16'hF000, data_mod_i = 3 -> 3 valid cycles carrying 1,1,1. busy_o drops after cycle 3. data_i bits below 13 never appear.
- Accept 16'h8001 (mod 0); pulse data_val_i = 1 with data_i = 16'hFFFF at bit 5 and again at the last bit -> both requests ignored, output stream unchanged. A request held high continuously is accepted on the first IDLE cycle, giving a one-cycle gap.
- Accept 16'h1234 (mod 0), change data_i and data_mod_i every cycle during SEND -> output remains 0,0,0,1,0,0,1,0,0,0,1,1,0,1,0,0.
- Assert srst_i asynchronously (between edges) at bit 7 of a 16-bit transfer -> all outputs go to 0 immediately. After release with data_val_i = 0, the outputs stay idle. A new word, 16'h0F0F, is then sent completely and correctly.
- data_mod_i = 1 with data_i = 16'h8000 -> a single valid cycle with ser_data_o = 1; busy_o is high for one cycle.
